// File: rtl/msg_queue.sv
// Message queue: FWFT buffer between the parser and its consumer.
// Option MSG_QUEUE_DROP_ERR_EN: discard error messages instead of queuing them.
module msg_queue #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_msg_valid,
  input  logic [15:0]                in_msg_length,
  input  logic [8*MAX_MSG_BYTES-1:0] in_msg_data,
  input  logic                       in_msg_error,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_length,
  output logic [8*MAX_MSG_BYTES-1:0] out_data,
  output logic                       out_error,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [CNT_WIDTH-1:0]       err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 8 * MAX_MSG_BYTES;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

  state_t state, state_nxt;

  logic [PW-1:0] wptr, rptr, count;
  logic [15:0]   len_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [DW-1:0] data_in;
  logic          err_in, pop, room;
  logic          wr, drop, err_inc;

  assign count   = wptr - rptr;
  assign q_count = count;

  assign err_in = in_msg_error
                | (in_msg_length == 16'd0)
                | (in_msg_length > 16'(MAX_MSG_BYTES));

  always_comb begin
    data_in = '0;
    for (int i = 0; i < MAX_MSG_BYTES; i++) begin
      if (16'(i) < in_msg_length)
        data_in[i*8 +: 8] = in_msg_data[i*8 +: 8];
    end
  end

  assign pop  = out_valid & out_ready;
  assign room = ~q_full | pop;

`ifdef MSG_QUEUE_DROP_ERR_EN
  assign wr      = in_msg_valid & ~err_in & room;
  assign drop    = in_msg_valid & ~err_in & ~room;
  assign err_inc = in_msg_valid & err_in;
`else
  assign wr      = in_msg_valid & room;
  assign drop    = in_msg_valid & ~room;
  assign err_inc = wr & err_in;
`endif

  always_ff @(posedge clk) begin
    if (wr) begin
      len_mem[wptr[AW-1:0]]  <= in_msg_length;
      data_mem[wptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (wr)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (drop && drop_count != '1)
        drop_count <= drop_count + CNT_WIDTH'(1);
      if (err_inc && err_count != '1)
        err_count <= err_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:
        if (wr) state_nxt = ACTIVE;
      ACTIVE: begin
        if (wr && !pop && count == LAST)
          state_nxt = FULL;
        else if (pop && !wr && count == PW'(1))
          state_nxt = EMPTY;
      end
      FULL:
        if (pop && !wr) state_nxt = ACTIVE;
      default:
        state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != EMPTY);
    q_full    = (state == FULL);
  end

  assign out_length = out_valid ? len_mem[rptr[AW-1:0]]  : '0;
  assign out_data   = out_valid ? data_mem[rptr[AW-1:0]] : '0;

`ifdef MSG_QUEUE_DROP_ERR_EN
  assign out_error = 1'b0;
`else
  logic err_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr)
      err_mem[wptr[AW-1:0]] <= err_in;
  end

  assign out_error = out_valid & err_mem[rptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_msg_queue.sv
// Bench for msg_queue: random and directed traffic against a queue-based
// reference model, with a negedge monitor comparing every cycle.
module tb_msg_queue;

  localparam int NB = 32;
  localparam int D  = 4;

  typedef struct {
    logic [15:0]     len;
    logic [8*NB-1:0] data;
    logic            err;
  } ent_t;

  logic            clk = 0;
  logic            rst = 1;
  logic            in_msg_valid = 0;
  logic [15:0]     in_msg_length = 0;
  logic [8*NB-1:0] in_msg_data = '0;
  logic            in_msg_error = 0;
  logic            out_valid;
  logic            out_ready = 0;
  logic [15:0]     out_length;
  logic [8*NB-1:0] out_data;
  logic            out_error;
  logic [2:0]      q_count;
  logic            q_full;
  logic [15:0]     drop_count;
  logic [15:0]     err_count;

  msg_queue dut (
    .clk(clk), .rst(rst),
    .in_msg_valid(in_msg_valid), .in_msg_length(in_msg_length),
    .in_msg_data(in_msg_data), .in_msg_error(in_msg_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_length(out_length), .out_data(out_data),
    .out_error(out_error), .q_count(q_count), .q_full(q_full),
    .drop_count(drop_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  bit   mon_en  = 0;
  ent_t exp_q[$];
  int   m_drop = 0;
  int   m_err  = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // reference model: an ideal bounded queue built from the rules
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_drop = 0;
      m_err  = 0;
    end else begin
      bit   pop, bad;
      ent_t e;
      int   n;
      n   = exp_q.size();
      pop = (n != 0) && out_ready;
      if (pop) void'(exp_q.pop_front());
      if (in_msg_valid) begin
        int l;
        l = int'(in_msg_length);
        bad = in_msg_error || l == 0 || l > NB;
        e.len  = in_msg_length;
        e.data = in_msg_data;
        for (int b = 0; b < NB; b++)
          if (b >= l) e.data[b*8 +: 8] = 8'h00;
        e.err = bad;
`ifdef MSG_QUEUE_DROP_ERR_EN
        if (bad) m_err++;
        else if (n < D || pop) exp_q.push_back(e);
        else m_drop++;
`else
        if (n < D || pop) begin
          exp_q.push_back(e);
          if (bad) m_err++;
        end else m_drop++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      n = exp_q.size();
      chk("out_valid", 256'(out_valid), 256'(n != 0));
      chk("q_count", 256'(q_count), 256'(n));
      chk("q_full", 256'(q_full), 256'(n == D));
      chk("drop_count", 256'(drop_count), 256'(sat(m_drop)));
      chk("err_count", 256'(err_count), 256'(sat(m_err)));
      if (n != 0) begin
        chk("head_len", 256'(out_length), 256'(exp_q[0].len));
        chk("head_data", out_data, exp_q[0].data);
`ifdef MSG_QUEUE_DROP_ERR_EN
        chk("head_err", 256'(out_error), 256'(0));
`else
        chk("head_err", 256'(out_error), 256'(exp_q[0].err));
`endif
      end else begin
        chk("idle_outs", {out_data, out_length, out_error},
            {{(8*NB){1'b0}}, 16'h0, 1'b0});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] len, input logic e);
    in_msg_valid  = 1;
    in_msg_length = len;
    in_msg_data   = rnd256();
    in_msg_error  = e;
    cyc();
    in_msg_valid  = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    repeat (D + 2) cyc();
    out_ready = 0;
  endtask

  initial begin
    logic [255:0] d;
    repeat (2) cyc();
    mon_en = 1;
    rst = 0;
    @(negedge clk);
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_full", 256'(q_full), 256'(0));
    cyc();

    // single pass-through with out-of-range bytes set
    out_ready = 1;
    d = '1;
    d[39:0] = 40'h0504030201;
    in_msg_valid = 1; in_msg_length = 5;
    in_msg_data = d; in_msg_error = 0;
    cyc();
    in_msg_valid = 0;
    @(negedge clk);
    chk("pt_valid", 256'(out_valid), 256'(1));
    chk("pt_len", 256'(out_length), 256'(5));
    chk("pt_data", out_data, 256'h0504030201);
    chk("pt_err", 256'(out_error), 256'(0));
    cyc();
    out_ready = 0;
    cyc();

    // fill, hold and drop
    for (int i = 0; i < 5; i++) put(16'(i + 1), 0);
    @(negedge clk);
    chk("fill_full", 256'(q_full), 256'(1));
    chk("fill_count", 256'(q_count), 256'(4));
    chk("fill_drop", 256'(drop_count), 256'(1));
    drain();

    // write and pop together while full
    for (int i = 0; i < 4; i++) put(16'(10 + i), 0);
    out_ready = 1;
    put(16'd20, 0);
    out_ready = 0;
    @(negedge clk);
    chk("wp_count", 256'(q_count), 256'(4));
    chk("wp_drop", 256'(drop_count), 256'(1));
    drain();

    // error marking
    put(16'd0, 0);
    put(16'd40, 0);
    put(16'd8, 1);
    @(negedge clk);
    chk("err_cnt", 256'(err_count), 256'(3));
`ifdef MSG_QUEUE_DROP_ERR_EN
    chk("err_q", 256'(q_count), 256'(0));
`else
    chk("err_q", 256'(q_count), 256'(3));
`endif
    drain();

    // reset mid-operation
    for (int i = 0; i < 3; i++) put(16'(3 + i), 0);
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("mr_count", 256'(q_count), 256'(0));
    chk("mr_valid", 256'(out_valid), 256'(0));
    chk("mr_ctrs", 256'({drop_count, err_count}), 256'(0));
    put(16'd7, 0);
    @(negedge clk);
    chk("mr_next", 256'(q_count), 256'(1));
    drain();

    // stream through the pointer wrap
    out_ready = 1;
    for (int i = 0; i < 10; i++) put(16'($urandom_range(1, NB)), 0);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready     = 1'($urandom_range(0, 1));
      in_msg_valid  = ($urandom_range(0, 2) != 0);
      in_msg_length = 16'($urandom_range(0, 40));
      in_msg_data   = rnd256();
      in_msg_error  = ($urandom_range(0, 7) == 0);
      cyc();
    end
    in_msg_valid = 0;
    drain();

    // drop counter saturation
    in_msg_valid  = 1;
    in_msg_length = 16'd4;
    in_msg_error  = 0;
    repeat (65545) cyc();
    in_msg_valid = 0;
    @(negedge clk);
    chk("sat_drop", 256'(drop_count), 256'(16'hFFFF));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
